// File: rtl/flappy_game_ctrl.sv
// flappy_game_ctrl - game sequencing for the flappy-bird core.
//
// Runs the IDLE/PLAY/DYING/OVER state machine, per-frame bird physics, pipe
// scrolling, pseudo-random gap generation and a saturating 3-digit BCD score.
// Game state only changes on frame_tick_i (except a collision, which ends
// PLAY on the next cycle), so every output is stable within a frame.
//
// Ports
//   pix_clk_i     pixel clock, all logic on the rising edge
//   reset_i       asynchronous, active-high reset
//   frame_tick_i  1-cycle pulse per frame (start of vertical blank)
//   flap_i        1-cycle debounced button-press pulse
//   collide_i     bird/pipe overlap level from the graphic logic
//   state_o       0=IDLE 1=PLAY 2=DYING 3=OVER
//   bird_y_o      bird top edge y (px)
//   bird_vel_o    signed bird velocity (px/frame)
//   scroll_x_o    pipe scroll offset, 0..PIPE_PITCH-1
//   gap0_y_o      gap top y of the on-screen pipe
//   gap1_y_o      gap top y of the next pipe
//   score_bcd_o   3-digit BCD score, saturates at 999
module flappy_game_ctrl #(
   parameter int unsigned SCREEN_H     = 480,
   parameter int unsigned BIRD_H       = 24,
   parameter int unsigned BIRD_Y0      = 228,
   parameter int unsigned GRAVITY      = 1,
   parameter int          FLAP_VEL     = -8,
   parameter int unsigned VEL_MAX      = 10,
   parameter int unsigned SCROLL_STEP  = 2,
   parameter int unsigned PIPE_PITCH   = 320,
   parameter int unsigned GAP_MIN      = 64,
   parameter int unsigned DEATH_FRAMES = 60
) (
   input  logic        pix_clk_i,
   input  logic        reset_i,
   input  logic        frame_tick_i,
   input  logic        flap_i,
   input  logic        collide_i,
   output logic [1:0]  state_o,
   output logic [9:0]  bird_y_o,
   output logic [5:0]  bird_vel_o,
   output logic [9:0]  scroll_x_o,
   output logic [9:0]  gap0_y_o,
   output logic [9:0]  gap1_y_o,
   output logic [11:0] score_bcd_o
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PLAY  = 2'd1,
      ST_DYING = 2'd2,
      ST_OVER  = 2'd3
   } state_e;

   localparam logic [9:0]  GROUND    = 10'(SCREEN_H - BIRD_H);
   localparam logic [9:0]  Y_RST     = 10'(BIRD_Y0);
   localparam logic [9:0]  GAP_RST   = 10'(GAP_MIN + 128);
   localparam logic [9:0]  GAP_BASE  = 10'(GAP_MIN);
   localparam logic [5:0]  FLAP_V    = 6'(FLAP_VEL);
   localparam logic [5:0]  VMAX      = 6'(VEL_MAX);
   localparam logic [5:0]  GRAV      = 6'(GRAVITY);
   localparam logic [10:0] STEP      = 11'(SCROLL_STEP);
   localparam logic [10:0] PITCH     = 11'(PIPE_PITCH);
   localparam logic [5:0]  DCNT_LAST = 6'(DEATH_FRAMES - 1);
   localparam logic [15:0] LFSR_SEED = 16'hACE1;

   state_e      state_q, state_d;
   logic [9:0]  bird_y_q, bird_y_d;
   logic [5:0]  bird_vel_q, bird_vel_d;
   logic [9:0]  scroll_x_q, scroll_x_d;
   logic [9:0]  gap0_y_q, gap0_y_d;
   logic [9:0]  gap1_y_q, gap1_y_d;
   logic [11:0] score_q, score_d;
   logic        flap_pend_q, flap_pend_d;
   logic [5:0]  death_cnt_q, death_cnt_d;
   logic [15:0] lfsr_q, lfsr_d;

   logic               flap_seen;
   logic signed [10:0] y_sum;
   logic signed [10:0] ground_s;
   logic [9:0]         y_clamp;
   logic               ground_hit;
   logic [5:0]         vel_inc;
   logic [5:0]         vel_fall;
   logic [10:0]        scroll_sum;
   logic               scroll_wrap;
   logic [11:0]        score_inc;

   // A flap arriving in the same cycle as a tick is seen by that tick.
   assign flap_seen = flap_pend_q | flap_i;

   // Physics in 11-bit signed so upward motion past the top stays negative.
   assign ground_s   = $signed({1'b0, GROUND});
   assign y_sum      = $signed({1'b0, bird_y_q}) + $signed({{5{bird_vel_q[5]}}, bird_vel_q});
   assign ground_hit = (y_sum >= ground_s);

   always_comb begin
      if (y_sum < 11'sd0) begin
         y_clamp = '0;
      end else if (y_sum > ground_s) begin
         y_clamp = GROUND;
      end else begin
         y_clamp = y_sum[9:0];
      end
   end

   assign vel_inc  = bird_vel_q + GRAV;
   assign vel_fall = ($signed(vel_inc) > $signed(VMAX)) ? VMAX : vel_inc;

   assign scroll_sum  = {1'b0, scroll_x_q} + STEP;
   assign scroll_wrap = (scroll_sum >= PITCH);

   // Per-digit BCD increment, holding at 999.
   always_comb begin
      score_inc = score_q;
      if (score_q != 12'h999) begin
         if (score_q[3:0] == 4'd9) begin
            score_inc[3:0] = 4'd0;
            if (score_q[7:4] == 4'd9) begin
               score_inc[7:4]  = 4'd0;
               score_inc[11:8] = score_q[11:8] + 4'd1;
            end else begin
               score_inc[7:4] = score_q[7:4] + 4'd1;
            end
         end else begin
            score_inc[3:0] = score_q[3:0] + 4'd1;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      bird_y_d    = bird_y_q;
      bird_vel_d  = bird_vel_q;
      scroll_x_d  = scroll_x_q;
      gap0_y_d    = gap0_y_q;
      gap1_y_d    = gap1_y_q;
      score_d     = score_q;
      flap_pend_d = flap_seen;
      death_cnt_d = death_cnt_q;
      // Fibonacci taps 16,14,13,11; free-running in every state.
      lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

      case (state_q)
         ST_IDLE: begin
            if (frame_tick_i) begin
               flap_pend_d = 1'b0;
               if (flap_seen) begin
                  state_d    = ST_PLAY;
                  bird_vel_d = FLAP_V;
               end
            end
         end

         ST_PLAY: begin
            // Collision wins over a same-cycle tick: no frame update at all.
            if (collide_i) begin
               state_d     = ST_DYING;
               flap_pend_d = 1'b0;
               death_cnt_d = '0;
            end else if (frame_tick_i) begin
               flap_pend_d = 1'b0;
               bird_y_d    = y_clamp;
               bird_vel_d  = flap_seen ? FLAP_V : vel_fall;
               if (scroll_wrap) begin
                  scroll_x_d = 10'(scroll_sum - PITCH);
                  gap0_y_d   = gap1_y_q;
                  gap1_y_d   = GAP_BASE + {2'b00, lfsr_q[7:0]};
                  score_d    = score_inc;
               end else begin
                  scroll_x_d = scroll_sum[9:0];
               end
               if (ground_hit) begin
                  state_d     = ST_DYING;
                  death_cnt_d = '0;
               end
            end
         end

         ST_DYING: begin
            flap_pend_d = 1'b0;
            if (frame_tick_i) begin
               bird_y_d    = y_clamp;
               bird_vel_d  = vel_fall;
               death_cnt_d = death_cnt_q + 6'd1;
               // Landing is judged on the post-tick position, the timeout on
               // the pre-tick count, so DYING lasts at most DEATH_FRAMES ticks.
               if ((y_clamp == GROUND) || (death_cnt_q == DCNT_LAST)) begin
                  state_d = ST_OVER;
               end
            end
         end

         ST_OVER: begin
            if (frame_tick_i) begin
               flap_pend_d = 1'b0;
               if (flap_seen) begin
                  state_d     = ST_IDLE;
                  bird_y_d    = Y_RST;
                  bird_vel_d  = '0;
                  scroll_x_d  = '0;
                  gap0_y_d    = GAP_RST;
                  gap1_y_d    = GAP_RST;
                  score_d     = '0;
                  death_cnt_d = '0;
               end
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge pix_clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q     <= ST_IDLE;
         bird_y_q    <= Y_RST;
         bird_vel_q  <= '0;
         scroll_x_q  <= '0;
         gap0_y_q    <= GAP_RST;
         gap1_y_q    <= GAP_RST;
         score_q     <= '0;
         flap_pend_q <= 1'b0;
         death_cnt_q <= '0;
         lfsr_q      <= LFSR_SEED;
      end else begin
         state_q     <= state_d;
         bird_y_q    <= bird_y_d;
         bird_vel_q  <= bird_vel_d;
         scroll_x_q  <= scroll_x_d;
         gap0_y_q    <= gap0_y_d;
         gap1_y_q    <= gap1_y_d;
         score_q     <= score_d;
         flap_pend_q <= flap_pend_d;
         death_cnt_q <= death_cnt_d;
         lfsr_q      <= lfsr_d;
      end
   end

   assign state_o     = state_q;
   assign bird_y_o    = bird_y_q;
   assign bird_vel_o  = bird_vel_q;
   assign scroll_x_o  = scroll_x_q;
   assign gap0_y_o    = gap0_y_q;
   assign gap1_y_o    = gap1_y_q;
   assign score_bcd_o = score_q;

endmodule

// File: tb/tb_flappy_game_ctrl.sv
// Bench for flappy_game_ctrl: directed scenarios plus randomized play,
// all outputs compared every cycle against a behavioural game model.
module tb_flappy_game_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        tick = 1'b0;
   logic        flap = 1'b0;
   logic        col = 1'b0;
   logic [1:0]  state;
   logic [9:0]  bird_y;
   logic [5:0]  bird_vel;
   logic [9:0]  scroll_x;
   logic [9:0]  gap0_y;
   logic [9:0]  gap1_y;
   logic [11:0] score;

   int checks = 0;
   int failures = 0;

   // Game model (plain integers, decimal score).
   int m_state, m_y, m_vel, m_sx, m_g0, m_g1, m_score, m_dcnt, m_lfsr;
   bit m_pend;

   always #5 clk = ~clk;

   flappy_game_ctrl dut (
      .pix_clk_i    (clk),
      .reset_i      (rst),
      .frame_tick_i (tick),
      .flap_i       (flap),
      .collide_i    (col),
      .state_o      (state),
      .bird_y_o     (bird_y),
      .bird_vel_o   (bird_vel),
      .scroll_x_o   (scroll_x),
      .gap0_y_o     (gap0_y),
      .gap1_y_o     (gap1_y),
      .score_bcd_o  (score)
   );

   task automatic check_eq(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int to_bcd(input int s);
      return ((s / 100) << 8) | (((s / 10) % 10) << 4) | (s % 10);
   endfunction

   function automatic int clamp_y(input int s);
      if (s < 0) return 0;
      if (s > 456) return 456;
      return s;
   endfunction

   function automatic int fall(input int v);
      return (v + 1 > 10) ? 10 : v + 1;
   endfunction

   task automatic model_reset();
      m_state = 0; m_y = 228; m_vel = 0; m_sx = 0;
      m_g0 = 192; m_g1 = 192; m_score = 0; m_dcnt = 0; m_pend = 0;
   endtask

   task automatic model_step(input bit tk, input bit fl_in, input bit cl);
      bit fl;
      int s;
      fl = m_pend | fl_in;
      s  = m_y + m_vel;
      case (m_state)
         0: begin
            m_pend = tk ? 1'b0 : fl;
            if (tk && fl) begin m_state = 1; m_vel = -8; end
         end
         1: begin
            if (cl) begin
               m_state = 2; m_pend = 0; m_dcnt = 0;
            end else begin
               m_pend = tk ? 1'b0 : fl;
               if (tk) begin
                  m_y   = clamp_y(s);
                  m_vel = fl ? -8 : fall(m_vel);
                  m_sx  = m_sx + 2;
                  if (m_sx >= 320) begin
                     m_sx = m_sx - 320;
                     m_g0 = m_g1;
                     m_g1 = 64 + (m_lfsr % 256);
                     if (m_score < 999) m_score++;
                  end
                  if (s >= 456) begin m_state = 2; m_dcnt = 0; end
               end
            end
         end
         2: begin
            m_pend = 0;
            if (tk) begin
               m_y   = clamp_y(s);
               m_vel = fall(m_vel);
               if (m_y == 456 || m_dcnt == 59) m_state = 3;
               m_dcnt++;
            end
         end
         default: begin
            m_pend = tk ? 1'b0 : fl;
            if (tk && fl) model_reset();
         end
      endcase
      m_lfsr = ((m_lfsr << 1) | (((m_lfsr >> 15) ^ (m_lfsr >> 13) ^ (m_lfsr >> 12) ^ (m_lfsr >> 10)) & 1)) & 16'hFFFF;
   endtask

   task automatic cycle(input bit tk, input bit fl, input bit cl);
      tick = tk; flap = fl; col = cl;
      model_step(tk, fl, cl);
      @(posedge clk);
      #1;
      tick = 1'b0; flap = 1'b0; col = 1'b0;
      check_eq("state",    int'(state),            m_state);
      check_eq("bird_y",   int'(bird_y),           m_y);
      check_eq("bird_vel", int'($signed(bird_vel)), m_vel);
      check_eq("scroll_x", int'(scroll_x),         m_sx);
      check_eq("gap0_y",   int'(gap0_y),           m_g0);
      check_eq("gap1_y",   int'(gap1_y),           m_g1);
      check_eq("score",    int'(score),            to_bcd(m_score));
   endtask

   task automatic tick_frame(input bit fl);
      cycle(1'b0, 1'b0, 1'b0);
      cycle(1'b1, fl, 1'b0);
   endtask

   // Keeps the bird airborne: flap whenever it sinks below mid-screen.
   task automatic play_frames(input int n);
      for (int i = 0; i < n; i++) tick_frame(m_y > 250);
   endtask

   task automatic check_reset_values(input string tag);
      check_eq({tag, "_state"},  int'(state),    0);
      check_eq({tag, "_bird_y"}, int'(bird_y),   228);
      check_eq({tag, "_vel"},    int'(bird_vel), 0);
      check_eq({tag, "_scroll"}, int'(scroll_x), 0);
      check_eq({tag, "_gap0"},   int'(gap0_y),   192);
      check_eq({tag, "_gap1"},   int'(gap1_y),   192);
      check_eq({tag, "_score"},  int'(score),    0);
   endtask

   initial begin
      int old_g1, old_sx, old_score;

      // Power-on reset.
      repeat (2) @(posedge clk);
      #1;
      check_reset_values("por");
      rst = 1'b0;
      model_reset();
      m_lfsr = 16'hACE1;

      // Idle: ticks without a flap change nothing.
      for (int i = 0; i < 5; i++) tick_frame(1'b0);
      check_reset_values("idle5");

      // Start with a separate flap then a tick.
      cycle(1'b0, 1'b1, 1'b0);
      cycle(1'b1, 1'b0, 1'b0);
      check_eq("start_state", int'(state), 1);
      check_eq("start_vel", int'($signed(bird_vel)), -8);
      check_eq("start_y", int'(bird_y), 228);
      tick_frame(1'b0);
      check_eq("f1_y", int'(bird_y), 220);
      check_eq("f1_vel", int'($signed(bird_vel)), -7);
      tick_frame(1'b0);
      check_eq("f2_y", int'(bird_y), 213);

      // Free fall to the ground.
      for (int i = 0; i < 200 && m_state == 1; i++) tick_frame(1'b0);
      check_eq("ground_state", int'(state), 2);
      check_eq("ground_y", int'(bird_y), 456);
      check_eq("ground_vel", int'($signed(bird_vel)), 10);
      tick_frame(1'b1);
      check_eq("over_state", int'(state), 3);

      // Restart from OVER.
      cycle(1'b0, 1'b1, 1'b0);
      cycle(1'b1, 1'b0, 1'b0);
      check_reset_values("restart");

      // 160 frames of flying: one full pipe pitch.
      tick_frame(1'b1);
      old_g1 = m_g1;
      play_frames(160);
      check_eq("wrap_state", int'(state), 1);
      check_eq("wrap_scroll", int'(scroll_x), 0);
      check_eq("wrap_score", int'(score), 12'h001);
      check_eq("wrap_gap0", int'(gap0_y), old_g1);

      // Collision on the same cycle as a tick.
      play_frames(7);
      old_sx = m_sx;
      old_score = m_score;
      cycle(1'b1, 1'b0, 1'b1);
      check_eq("col_state", int'(state), 2);
      check_eq("col_scroll", int'(scroll_x), old_sx);
      check_eq("col_score", int'(score), to_bcd(old_score));
      for (int i = 0; i < 100 && m_state == 2; i++) tick_frame(1'b1);
      check_eq("col_over", int'(state), 3);

      // Score saturation near 999.
      tick_frame(1'b1);
      tick_frame(1'b1);
      force dut.score_q = 12'h998;
      m_score = 998;
      cycle(1'b0, 1'b0, 1'b0);
      release dut.score_q;
      play_frames(160);
      check_eq("sat_999", int'(score), 12'h999);
      play_frames(160);
      check_eq("sat_hold", int'(score), 12'h999);
      check_eq("sat_state", int'(state), 1);

      // Asynchronous reset mid-game with a flap pending.
      cycle(1'b0, 1'b1, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      check_reset_values("async");
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      m_lfsr = 16'hACE1;
      tick_frame(1'b0);
      check_eq("no_pend_state", int'(state), 0);

      // Randomized play.
      for (int i = 0; i < 15000; i++) begin
         cycle($urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0, $urandom_range(0, 299) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
